// File: rtl/fp_pkg.sv
// Shared field widths, sum bit positions and FSM states for the
// single-precision adder back end.
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SUM_W  = 28;
  localparam int MAG_W  = SUM_W - 1;

  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

  localparam int CARRY  = 26;
  localparam int HIDDEN = 25;
  localparam int GUARD  = 1;
  localparam int STICKY = 0;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_e;
endpackage

// File: rtl/fp_norm_pack_if.sv
// Input (sum/exponent) and output (packed result) handshakes of the
// normalize/round/pack stage.
interface fp_norm_pack_if;
  import fp_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [SUM_W-1:0]   sum;
  logic [EXP_W-1:0]   exp_in;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        result;

  modport slave (
    input  in_valid, sum, exp_in, out_ready,
    output in_ready, out_valid, result
  );

  modport master (
    output in_valid, sum, exp_in, out_ready,
    input  in_ready, out_valid, result
  );
endinterface

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even on a normalized magnitude, renormalize on
// mantissa carry-out, and pack an IEEE-754 single (infinity on overflow).
module fp_round_pack
  import fp_pkg::*;
(
  input  logic              sgn_i,
  input  logic [HIDDEN:0]   mag_i,
  input  logic [EXP_W:0]    exp_i,
  input  logic              sticky_i,
  output logic [31:0]       result_o
);

  function automatic logic round_up(input logic lsb, input logic g, input logic rs);
    return g & (rs | lsb);
  endfunction

  logic              up;
  logic [FRAC_W+1:0] m25;
  logic [FRAC_W:0]   m24;
  logic [EXP_W:0]    exp_r;

  always_comb begin
    up  = round_up(mag_i[GUARD+1], mag_i[GUARD], mag_i[STICKY] | sticky_i);
    m25 = {1'b0, mag_i[HIDDEN:GUARD+1]} + (FRAC_W+2)'(up);
    if (m25[FRAC_W+1]) begin
      m24   = m25[FRAC_W+1:1];
      exp_r = exp_i + 9'd1;
    end else begin
      m24   = m25[FRAC_W:0];
      exp_r = exp_i;
    end
    if (exp_r >= 9'd255) result_o = {sgn_i, EXP_INF, {FRAC_W{1'b0}}};
    else                 result_o = {sgn_i, exp_r[EXP_W-1:0], m24[FRAC_W-1:0]};
  end

endmodule

// File: rtl/fp_norm_pack.sv
// Normalizes a sign-magnitude mantissa sum one bit per cycle, then rounds
// and packs it into an IEEE-754 single behind valid/ready handshakes.
module fp_norm_pack
  import fp_pkg::*;
#(
  parameter int MAX_LSHIFT = 25
) (
  input  logic               clk,
  input  logic               res,
  fp_norm_pack_if.slave      bus,
  output logic               busy
);

  localparam int CNT_W = $clog2(MAX_LSHIFT + 1);

  state_e             state_q, state_d;
  logic               sgn_q, sgn_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic [EXP_W:0]     exp_q, exp_d;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        result_q, result_d;
  logic [31:0]        rp_result;

  fp_round_pack u_round_pack (
    .sgn_i    (sgn_q),
    .mag_i    (mag_q[HIDDEN:0]),
    .exp_i    (exp_q),
    .sticky_i (sticky_q),
    .result_o (rp_result)
  );

  always_comb begin
    state_d  = state_q;
    sgn_d    = sgn_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sgn_d    = bus.sum[SUM_W-1];
          mag_d    = bus.sum[MAG_W-1:0];
          exp_d    = {1'b0, bus.exp_in};
          sticky_d = 1'b0;
          cnt_d    = '0;
          // An all-ones exponent can only mean overflow upstream.
          if (bus.exp_in == EXP_INF) begin
            result_d = {bus.sum[SUM_W-1], EXP_INF, {FRAC_W{1'b0}}};
            state_d  = DONE;
          end else begin
            state_d  = NORM;
          end
        end
      end
      NORM: begin
        if (mag_q == '0) begin
          result_d = 32'h0000_0000;
          state_d  = DONE;
        end else if (mag_q[CARRY]) begin
          mag_d    = mag_q >> 1;
          sticky_d = sticky_q | mag_q[0];
          exp_d    = exp_q + 9'd1;
          state_d  = ROUND;
        end else if (mag_q[HIDDEN]) begin
          state_d  = ROUND;
        end else if (exp_q == 9'd1 || cnt_q == CNT_W'(MAX_LSHIFT)) begin
          // Another left shift would need a denormal: flush to signed zero.
          result_d = {sgn_q, 31'b0};
          state_d  = DONE;
        end else begin
          mag_d    = mag_q << 1;
          exp_d    = exp_q - 9'd1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      ROUND: begin
        result_d = rp_result;
        state_d  = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= IDLE;
      result_q <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    sgn_q    <= sgn_d;
    mag_q    <= mag_d;
    exp_q    <= exp_d;
    sticky_q <= sticky_d;
    cnt_q    <= cnt_d;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign busy          = (state_q != IDLE);

endmodule
